cursor_nav: RTL and testbench

- Parametrised cursor/viewport controller for the life-game board. It turns the direction, zoom and move-mode command bits into a cursor position and a window origin on a toroidal MAP_W x MAP_H board.
- Beyond the earlier controller it adds: divider-free wrap-around, hold-to-auto-repeat, working zoom with power-of-two view widths, window follow (the cursor stays visible), and run-mode lockout of cursor edits.
- Sits between the key/command decoder and the display/cell-edit logic.

---
 rtl/cursor_nav_pkg.sv | 27 ++
 rtl/cursor_nav_key_repeat.sv | 106 ++++++++++
 rtl/cursor_nav.sv | 201 ++++++++++++++++++++
 tb/tb_cursor_nav.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cursor_nav_pkg.sv
// Shared command-bit indices, coordinate width and mode encoding for the
// life-board cursor/viewport controller.
package cursor_nav_pkg;

    localparam int ADDR_WIDTH = 8;
    localparam int CMD_W      = 7;

    localparam int M_UP    = 0;
    localparam int M_DOWN  = 1;
    localparam int M_LEFT  = 2;
    localparam int M_RIGHT = 3;
    localparam int Z_IN    = 4;
    localparam int Z_OUT   = 5;
    localparam int M_MODE  = 6;

    localparam logic MODE_RUN  = 1'b1;
    localparam logic MODE_EDIT = 1'b0;

    // Values match the direction bit indices so a key vector can be indexed by them.
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

endpackage

// File: rtl/cursor_nav_key_repeat.sv
// Direction key front end: rising-edge detect, up>down>left>right priority,
// and hold-then-auto-repeat timing.
module key_repeat
    import cursor_nav_pkg::*;
#(
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] keys,
    input  logic       abort,
    output logic       step_pulse,
    output dir_e       dir
);

    localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dir_e             latched_q, latched_d;
    logic [3:0]       prev_q;
    logic [3:0]       rise;
    dir_e             sel;
    logic             any_key;
    logic             hold_lost;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_edge
            assign rise[gi] = keys[gi] & ~prev_q[gi];
        end
    endgenerate

    always_comb begin
        sel = DIR_RIGHT;
        if (keys[M_UP])        sel = DIR_UP;
        else if (keys[M_DOWN]) sel = DIR_DOWN;
        else if (keys[M_LEFT]) sel = DIR_LEFT;
    end

    assign any_key   = |keys;
    assign hold_lost = abort | ~keys[latched_q] | (sel != latched_q);
    assign dir       = sel;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        latched_d  = latched_q;
        step_pulse = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!abort && any_key && rise[sel]) begin
                    step_pulse = 1'b1;
                    latched_d  = sel;
                    state_d    = ST_DELAY;
                    cnt_d      = '0;
                end
            end
            ST_DELAY: begin
                if (hold_lost) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == HOLD_LAST) begin
                    step_pulse = 1'b1;
                    state_d    = ST_REPEAT;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_REPEAT: begin
                if (hold_lost) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == REPEAT_LAST) begin
                    step_pulse = 1'b1;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            latched_q <= DIR_UP;
            prev_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            latched_q <= latched_d;
            prev_q    <= keys;
        end
    end

endmodule

// File: rtl/cursor_nav.sv
// Cursor and viewport controller on a toroidal board: stepping, auto-repeat,
// power-of-two zoom and window follow, all with divider-free wrap arithmetic.
module cursor_nav
    import cursor_nav_pkg::*;
#(
    parameter int MAP_W         = 32,
    parameter int MAP_H         = 32,
    parameter int AW            = ADDR_WIDTH,
    parameter int VIEW_MIN      = 4,
    parameter int VIEW_MAX      = 32,
    parameter int VIEW_INIT     = 8,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000,
    parameter int INIT_CUR_X    = 3,
    parameter int INIT_CUR_Y    = 3,
    parameter int INIT_WIN_X    = 0,
    parameter int INIT_WIN_Y    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [CMD_W-1:0] win_ctrl_cmd,
    output logic [AW-1:0]    win_x,
    output logic [AW-1:0]    win_y,
    output logic [AW-1:0]    cur_x,
    output logic [AW-1:0]    cur_y,
    output logic [AW-1:0]    cur_rx,
    output logic [AW-1:0]    cur_ry,
    output logic [7:0]       view_width,
    output logic             moved
);

    localparam logic [AW-1:0] LAST_X = AW'(MAP_W - 1);
    localparam logic [AW-1:0] LAST_Y = AW'(MAP_H - 1);
    localparam logic [AW:0]   FULL_X = (AW+1)'(MAP_W);
    localparam logic [AW:0]   FULL_Y = (AW+1)'(MAP_H);

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] v, input logic [AW-1:0] last);
        return (v == last) ? '0 : v + 1'b1;
    endfunction

    function automatic logic [AW-1:0] wrap_dec(input logic [AW-1:0] v, input logic [AW-1:0] last);
        return (v == '0) ? last : v - 1'b1;
    endfunction

    // a - b modulo the board size, assuming both operands are already on the board.
    function automatic logic [AW-1:0] wrap_sub(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                               input logic [AW:0] full);
        logic [AW:0] diff;
        if (a >= b) diff = {1'b0, a} - {1'b0, b};
        else        diff = {1'b0, a} + full - {1'b0, b};
        return diff[AW-1:0];
    endfunction

    logic [AW-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [AW-1:0] win_x_q, win_x_d, win_y_q, win_y_d;
    logic [AW-1:0] rx_q, rx_d, ry_q, ry_d;
    logic [7:0]    view_q, view_d;
    logic          moved_q, moved_d;
    logic          zin_prev_q, zout_prev_q, mode_prev_q, mmode_prev_q, primed_q;

    logic zin_rise, zout_rise, zoom_req, abort, step_pulse;
    logic at_left, at_right, at_top, at_bottom, drag_x, drag_y;
    dir_e dir;

    assign zin_rise  = win_ctrl_cmd[Z_IN]  & ~zin_prev_q;
    assign zout_rise = win_ctrl_cmd[Z_OUT] & ~zout_prev_q;
    assign zoom_req  = primed_q & (zin_rise ^ zout_rise);
    // The first cycle out of reset only records key history, so a key held
    // through reset never counts as a fresh press.
    assign abort = ~primed_q | (mode != mode_prev_q) | (win_ctrl_cmd[M_MODE] != mmode_prev_q);

    key_repeat #(
        .HOLD_CYCLES  (HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_key_repeat (
        .clk       (clk),
        .rst       (rst),
        .keys      ({win_ctrl_cmd[M_RIGHT], win_ctrl_cmd[M_LEFT],
                     win_ctrl_cmd[M_DOWN], win_ctrl_cmd[M_UP]}),
        .abort     (abort),
        .step_pulse(step_pulse),
        .dir       (dir)
    );

    assign at_left   = (rx_q == '0);
    assign at_top    = (ry_q == '0);
    assign at_right  = (32'(rx_q) == 32'(view_q) - 32'd1);
    assign at_bottom = (32'(ry_q) == 32'(view_q) - 32'd1);
    // A view spanning the whole board can never lose the cursor.
    assign drag_x    = (32'(view_q) < 32'(MAP_W));
    assign drag_y    = (32'(view_q) < 32'(MAP_H));

    always_comb begin
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        win_x_d = win_x_q;
        win_y_d = win_y_q;
        view_d  = view_q;
        if (zoom_req) begin
            if (zin_rise) begin
                if (view_q != 8'(VIEW_MIN)) begin
                    view_d = view_q >> 1;
                    if (32'(rx_q) >= 32'(view_d))
                        win_x_d = wrap_sub(cur_x_q, AW'(view_d >> 1), FULL_X);
                    if (32'(ry_q) >= 32'(view_d))
                        win_y_d = wrap_sub(cur_y_q, AW'(view_d >> 1), FULL_Y);
                end
            end else if (view_q != 8'(VIEW_MAX)) begin
                view_d = view_q << 1;
            end
        end else if (step_pulse) begin
            if (win_ctrl_cmd[M_MODE]) begin
                // Window moves; the cursor is dragged only if it would leave the view.
                case (dir)
                    DIR_UP: begin
                        win_y_d = wrap_dec(win_y_q, LAST_Y);
                        if (drag_y && at_bottom) cur_y_d = wrap_dec(cur_y_q, LAST_Y);
                    end
                    DIR_DOWN: begin
                        win_y_d = wrap_inc(win_y_q, LAST_Y);
                        if (drag_y && at_top) cur_y_d = wrap_inc(cur_y_q, LAST_Y);
                    end
                    DIR_LEFT: begin
                        win_x_d = wrap_dec(win_x_q, LAST_X);
                        if (drag_x && at_right) cur_x_d = wrap_dec(cur_x_q, LAST_X);
                    end
                    default: begin
                        win_x_d = wrap_inc(win_x_q, LAST_X);
                        if (drag_x && at_left) cur_x_d = wrap_inc(cur_x_q, LAST_X);
                    end
                endcase
            end else if (mode == MODE_EDIT) begin
                case (dir)
                    DIR_UP: begin
                        cur_y_d = wrap_dec(cur_y_q, LAST_Y);
                        if (at_top) win_y_d = wrap_dec(win_y_q, LAST_Y);
                    end
                    DIR_DOWN: begin
                        cur_y_d = wrap_inc(cur_y_q, LAST_Y);
                        if (at_bottom) win_y_d = wrap_inc(win_y_q, LAST_Y);
                    end
                    DIR_LEFT: begin
                        cur_x_d = wrap_dec(cur_x_q, LAST_X);
                        if (at_left) win_x_d = wrap_dec(win_x_q, LAST_X);
                    end
                    default: begin
                        cur_x_d = wrap_inc(cur_x_q, LAST_X);
                        if (at_right) win_x_d = wrap_inc(win_x_q, LAST_X);
                    end
                endcase
            end
        end
        rx_d    = wrap_sub(cur_x_d, win_x_d, FULL_X);
        ry_d    = wrap_sub(cur_y_d, win_y_d, FULL_Y);
        moved_d = (cur_x_d != cur_x_q) | (cur_y_d != cur_y_q) | (win_x_d != win_x_q) |
                  (win_y_d != win_y_q) | (view_d != view_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_x_q      <= AW'(INIT_CUR_X);
            cur_y_q      <= AW'(INIT_CUR_Y);
            win_x_q      <= AW'(INIT_WIN_X);
            win_y_q      <= AW'(INIT_WIN_Y);
            rx_q         <= wrap_sub(AW'(INIT_CUR_X), AW'(INIT_WIN_X), FULL_X);
            ry_q         <= wrap_sub(AW'(INIT_CUR_Y), AW'(INIT_WIN_Y), FULL_Y);
            view_q       <= 8'(VIEW_INIT);
            moved_q      <= 1'b0;
            zin_prev_q   <= 1'b0;
            zout_prev_q  <= 1'b0;
            mode_prev_q  <= 1'b0;
            mmode_prev_q <= 1'b0;
            primed_q     <= 1'b0;
        end else begin
            cur_x_q      <= cur_x_d;
            cur_y_q      <= cur_y_d;
            win_x_q      <= win_x_d;
            win_y_q      <= win_y_d;
            rx_q         <= rx_d;
            ry_q         <= ry_d;
            view_q       <= view_d;
            moved_q      <= moved_d;
            zin_prev_q   <= win_ctrl_cmd[Z_IN];
            zout_prev_q  <= win_ctrl_cmd[Z_OUT];
            mode_prev_q  <= mode;
            mmode_prev_q <= win_ctrl_cmd[M_MODE];
            primed_q     <= 1'b1;
        end
    end

    assign cur_x      = cur_x_q;
    assign cur_y      = cur_y_q;
    assign win_x      = win_x_q;
    assign win_y      = win_y_q;
    assign cur_rx     = rx_q;
    assign cur_ry     = ry_q;
    assign view_width = view_q;
    assign moved      = moved_q;

endmodule

// File: tb/tb_cursor_nav.sv
// Directed bench for cursor_nav on an 8x8 board: expected state is queued
// as each command is driven and checked one edge later.
module tb_cursor_nav;

    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_UP   = 7'b0000001;
    localparam logic [6:0] C_DN   = 7'b0000010;
    localparam logic [6:0] C_LT   = 7'b0000100;
    localparam logic [6:0] C_RT   = 7'b0001000;
    localparam logic [6:0] C_ZI   = 7'b0010000;
    localparam logic [6:0] C_ZO   = 7'b0100000;
    localparam logic [6:0] C_MM   = 7'b1000000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       mode = 1'b0;
    logic [6:0] win_ctrl_cmd = '0;
    logic [7:0] win_x, win_y, cur_x, cur_y, cur_rx, cur_ry, view_width;
    logic       moved;

    cursor_nav #(
        .MAP_W(8), .MAP_H(8), .AW(8),
        .VIEW_MIN(2), .VIEW_MAX(8), .VIEW_INIT(4),
        .HOLD_CYCLES(10), .REPEAT_CYCLES(4),
        .INIT_CUR_X(3), .INIT_CUR_Y(3), .INIT_WIN_X(0), .INIT_WIN_Y(0)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .win_ctrl_cmd(win_ctrl_cmd),
        .win_x(win_x), .win_y(win_y), .cur_x(cur_x), .cur_y(cur_y),
        .cur_rx(cur_rx), .cur_ry(cur_ry), .view_width(view_width), .moved(moved)
    );

    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    cx, cy, wx, wy, rx, ry, vw, mv;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   e_cx, e_cy, e_wx, e_wy, e_rx, e_ry, e_vw, e_mv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag);
        exp_t e;
        e.tag = tag; e.cx = e_cx; e.cy = e_cy; e.wx = e_wx; e.wy = e_wy;
        e.rx = e_rx; e.ry = e_ry; e.vw = e_vw; e.mv = e_mv;
        sb_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sb_q.pop_front();
        chk({e.tag, ".cur_x"},  32'(cur_x),      32'(e.cx));
        chk({e.tag, ".cur_y"},  32'(cur_y),      32'(e.cy));
        chk({e.tag, ".win_x"},  32'(win_x),      32'(e.wx));
        chk({e.tag, ".win_y"},  32'(win_y),      32'(e.wy));
        chk({e.tag, ".cur_rx"}, 32'(cur_rx),     32'(e.rx));
        chk({e.tag, ".cur_ry"}, 32'(cur_ry),     32'(e.ry));
        chk({e.tag, ".view"},   32'(view_width), 32'(e.vw));
        chk({e.tag, ".moved"},  32'(moved),      32'(e.mv));
        $display("txn %-10s cur=(%0d,%0d) win=(%0d,%0d) rel=(%0d,%0d) view=%0d moved=%0d",
                 e.tag, cur_x, cur_y, win_x, win_y, cur_rx, cur_ry, view_width, moved);
    endtask

    // Drive one cycle of command bits; the expected state is queued first.
    task automatic run(input logic [6:0] cmd, input string tag);
        win_ctrl_cmd = cmd;
        push_exp(tag);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    task automatic set_reset_exp();
        e_cx = 3; e_cy = 3; e_wx = 0; e_wy = 0; e_rx = 3; e_ry = 3; e_vw = 4; e_mv = 0;
    endtask

    task automatic do_reset(input logic [6:0] held);
        win_ctrl_cmd = held;
        mode = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        set_reset_exp();
        push_exp("reset");
        pop_check();
        @(posedge clk);
        #1;
        rst = 1'b1;
        run(held, "prime");
    endtask

    initial begin
        bit step;
        @(posedge clk);
        #1;
        do_reset(C_NONE);

        // Cursor walks right; the window follows once the cursor is at the right edge.
        for (int k = 0; k < 4; k++) begin
            e_cx = 4 + k; e_wx = 1 + k; e_rx = 3; e_mv = 1;
            run(C_RT, $sformatf("tapR%0d", k));
            e_mv = 0;
            run(C_NONE, $sformatf("relR%0d", k));
        end

        // Left wrap from (cur=0, win=0).
        do_reset(C_NONE);
        for (int k = 0; k < 3; k++) begin
            e_cx = 2 - k; e_rx = 2 - k; e_mv = 1;
            run(C_LT, $sformatf("tapL%0d", k));
            e_mv = 0;
            run(C_NONE, $sformatf("relL%0d", k));
        end
        e_cx = 7; e_wx = 7; e_rx = 0; e_mv = 1;
        run(C_LT, "wrapL");
        e_mv = 0;
        run(C_NONE, "relWrap");

        // Hold down for 30 cycles: steps at 0, 10, 14, 18, 22, 26.
        do_reset(C_NONE);
        for (int i = 0; i < 30; i++) begin
            step = (i == 0) || (i >= 10 && ((i - 10) % 4) == 0);
            if (step) begin
                e_cy = (e_cy + 1) % 8;
                e_wy = (e_wy + 1) % 8;
            end
            e_mv = step ? 1 : 0;
            run(C_DN, $sformatf("holdD%0d", i));
        end
        chk("holdD.final_cur_y", 32'(cur_y), 32'd1);
        e_mv = 0;
        for (int i = 0; i < 6; i++) run(C_NONE, $sformatf("relD%0d", i));

        // Priority, run-mode lockout, window moves.
        do_reset(C_NONE);
        e_cy = 2; e_ry = 2; e_mv = 1;
        run(C_UP | C_DN, "upDown");
        e_mv = 0;
        run(C_NONE, "relUD");
        e_cx = 2; e_rx = 2; e_mv = 1;
        run(C_LT, "editL");
        e_mv = 0;
        run(C_NONE, "relEditL");
        mode = 1'b1;
        run(C_NONE, "runMode");
        run(C_LT, "runL");
        run(C_NONE, "relRunL");
        run(C_MM, "mmSet");
        e_wx = 7; e_rx = 3; e_mv = 1;
        run(C_MM | C_LT, "winL");
        e_mv = 0;
        run(C_MM, "relWinL");
        e_wx = 0; e_rx = 2; e_mv = 1;
        run(C_MM | C_RT, "winR");
        e_mv = 0;
        run(C_MM, "relWinR");

        // Zoom in/out, limits, simultaneous zoom keys, zoom beating a move.
        do_reset(C_NONE);
        e_vw = 2; e_wx = 2; e_wy = 2; e_rx = 1; e_ry = 1; e_mv = 1;
        run(C_ZI, "zin1");
        e_mv = 0;
        run(C_NONE, "relZin1");
        run(C_ZI, "zinMin");
        run(C_NONE, "relZin2");
        e_vw = 4; e_mv = 1;
        run(C_ZO, "zout1");
        e_mv = 0;
        run(C_NONE, "relZo1");
        e_vw = 8; e_mv = 1;
        run(C_ZO, "zout2");
        e_mv = 0;
        run(C_NONE, "relZo2");
        run(C_ZO, "zoutMax");
        run(C_NONE, "relZo3");
        run(C_ZI | C_ZO, "zBoth");
        run(C_NONE, "relZb");
        e_vw = 4; e_mv = 1;
        run(C_ZI | C_RT, "zinPlusR");
        e_mv = 0;
        for (int i = 0; i < 5; i++) run(C_RT, $sformatf("zHoldR%0d", i));
        run(C_NONE, "relZR");

        // Reset in the middle of auto-repeat, with the key still held.
        do_reset(C_NONE);
        for (int i = 0; i < 15; i++) begin
            step = (i == 0) || (i == 10) || (i == 14);
            if (step) begin
                e_cx = (e_cx + 1) % 8;
                e_wx = (e_wx + 1) % 8;
            end
            e_mv = step ? 1 : 0;
            run(C_RT, $sformatf("holdR%0d", i));
        end
        do_reset(C_RT);
        for (int i = 0; i < 20; i++) run(C_RT, $sformatf("heldR%0d", i));
        run(C_NONE, "relHeld");
        e_cx = 4; e_wx = 1; e_mv = 1;
        run(C_RT, "repress");
        e_mv = 0;
        run(C_NONE, "relRepress");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
